// File: rtl/adc_pcm_fifo.sv
// Sigma-delta ADC CIC output to signed PCM: re-centre, clip to FS_LOG2 bits,
// then buffer in a small FIFO with sticky overflow and saturating drop count.
module adc_pcm_fifo #(
    parameter int IN_WDTH = 20,
    parameter int FS_LOG2 = 16,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IN_WDTH-1:0]       adc_output,
    input  logic                     adc_valid,
    output logic [FS_LOG2-1:0]       pcm_data,
    output logic                     pcm_valid,
    input  logic                     pcm_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic                     sat_pulse,
    input  logic                     ovf_clr
);

    localparam int CW = IN_WDTH + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic signed [CW-1:0] MIDSCALE = CW'(2 ** (FS_LOG2 - 1));
    localparam logic signed [CW-1:0] CLIP_MAX = MIDSCALE - CW'(1);
    localparam logic signed [CW-1:0] CLIP_MIN = -MIDSCALE;
    localparam logic [LW-1:0]        FULL_LVL = LW'(DEPTH);
    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
    localparam logic [LW-1:0]        LVL_ONE  = LW'(1);

    // Stage 1: offset-binary to signed, computed one bit wider than the input.
    logic                   s1_valid;
    logic signed [CW-1:0]   s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= adc_valid;
            if (adc_valid) begin
                s1_data <= $signed({1'b0, adc_output}) - MIDSCALE;
            end
        end
    end

    // Stage 2: combinational clip; the write request is s1_valid itself.
    logic                 sat_hi;
    logic                 sat_lo;
    logic [FS_LOG2-1:0]   wr_data;
    logic                 wr_req;

    always_comb begin
        sat_hi = (s1_data > CLIP_MAX);
        sat_lo = (s1_data < CLIP_MIN);
        if (sat_hi) begin
            wr_data = {1'b0, {(FS_LOG2-1){1'b1}}};
        end else if (sat_lo) begin
            wr_data = {1'b1, {(FS_LOG2-1){1'b0}}};
        end else begin
            wr_data = s1_data[FS_LOG2-1:0];
        end
    end

    assign wr_req    = s1_valid;
    assign sat_pulse = s1_valid & (sat_hi | sat_lo);

    // Output handshake: pcm_valid means the head entry is stable; a transfer
    // happens at the rising edge where pcm_valid && pcm_ready, popping the head.
    logic [FS_LOG2-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [LW-1:0]      level;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    assign full  = (level == FULL_LVL);
    assign pop   = pcm_valid & pcm_ready;
    assign push  = wr_req & (~full | pop);
    assign drop  = wr_req & full & ~pop;

    assign pcm_valid  = (level != '0);
    assign pcm_data   = pcm_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
        end
    end

    // A drop in the same cycle as ovf_clr takes priority and restarts the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_adc_pcm_fifo.sv
// Directed bench for adc_pcm_fifo: conversion/clipping, FIFO order, overflow
// accounting, and asynchronous reset behaviour with hand-computed expectations.
module tb_adc_pcm_fifo;

    localparam int IN_W  = 20;
    localparam int FS    = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int MID   = 32768;

    logic             clk;
    logic             rst_n;
    logic [IN_W-1:0]  adc_output;
    logic             adc_valid;
    logic [FS-1:0]    pcm_data;
    logic             pcm_valid;
    logic             pcm_ready;
    logic [LW-1:0]    fifo_level;
    logic             overflow;
    logic [7:0]       drop_count;
    logic             sat_pulse;
    logic             ovf_clr;

    int n_checks = 0;
    int n_errors = 0;
    logic [FS-1:0] exp_q[$];

    adc_pcm_fifo #(
        .IN_WDTH (IN_W),
        .FS_LOG2 (FS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_output (adc_output),
        .adc_valid  (adc_valid),
        .pcm_data   (pcm_data),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .sat_pulse  (sat_pulse),
        .ovf_clr    (ovf_clr)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one adc_valid cycle; returns in the following cycle (stage-2 request).
    task automatic send(input logic [IN_W-1:0] v);
        adc_output = v;
        adc_valid  = 1'b1;
        tick();
        adc_valid  = 1'b0;
    endtask

    task automatic one_sample(input string tag, input logic [IN_W-1:0] v,
                              input logic [FS-1:0] exp_d, input logic exp_s);
        pcm_ready = 1'b1;
        send(v);
        check({tag, "_sat"}, 32'(sat_pulse), 32'(exp_s));
        check({tag, "_n1_valid"}, 32'(pcm_valid), 32'd0);
        tick();
        check({tag, "_n2_valid"}, 32'(pcm_valid), 32'd1);
        check({tag, "_n2_data"}, 32'(pcm_data), 32'(exp_d));
        check({tag, "_n2_sat"}, 32'(sat_pulse), 32'd0);
        tick();
        check({tag, "_popped"}, 32'(pcm_valid), 32'd0);
    endtask

    // Pops every expected entry in order, then expects the FIFO to be empty.
    task automatic drain_check(input string tag);
        pcm_ready = 1'b1;
        while (exp_q.size() > 0) begin
            check({tag, "_valid"}, 32'(pcm_valid), 32'd1);
            check({tag, "_data"}, 32'(pcm_data), 32'(exp_q.pop_front()));
            tick();
        end
        check({tag, "_empty"}, 32'(pcm_valid), 32'd0);
        check({tag, "_zero"}, 32'(pcm_data), 32'd0);
        pcm_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n      = 1'b0;
        adc_output = '0;
        adc_valid  = 1'b0;
        pcm_ready  = 1'b0;
        ovf_clr    = 1'b0;
        tick();
        tick();
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_valid", 32'(pcm_valid), 32'd0);
        check("rst_data", 32'(pcm_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        check("rst_sat", 32'(sat_pulse), 32'd0);
        rst_n = 1'b1;
        tick();

        // Conversion and clipping
        one_sample("mid", 20'd32768, 16'h0000, 1'b0);
        one_sample("zero", 20'd0, 16'h8000, 1'b0);
        one_sample("fs", 20'd65536, 16'h7FFF, 1'b1);
        one_sample("over", 20'd70000, 16'h7FFF, 1'b1);
        one_sample("top", 20'd65535, 16'h7FFF, 1'b0);

        // Nine back-to-back samples with no consumer: ninth is dropped
        pcm_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            adc_output = 20'(MID + k);
            adc_valid  = 1'b1;
            if (k <= DEPTH) exp_q.push_back(16'(k));
            tick();
        end
        adc_valid = 1'b0;
        tick();
        tick();
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd1);
        drain_check("ovf_pop");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_flag", 32'(overflow), 32'd0);
        check("clr_drops", 32'(drop_count), 32'd0);

        // Full FIFO: write coincident with a pop is accepted
        for (int k = 11; k <= 18; k++) begin
            send(20'(MID + k));
            if (k > 11) exp_q.push_back(16'(k));
        end
        tick();
        check("full_level", 32'(fifo_level), 32'd8);
        check("full_head", 32'(pcm_data), 32'd11);
        send(20'(MID + 19));
        pcm_ready = 1'b1;
        tick();
        pcm_ready = 1'b0;
        exp_q.push_back(16'd19);
        check("full_rw_level", 32'(fifo_level), 32'd8);
        check("full_rw_ovf", 32'(overflow), 32'd0);
        check("full_rw_drops", 32'(drop_count), 32'd0);
        drain_check("full_rw_pop");

        // Saturating drop counter, clear, and clear-vs-drop priority
        for (int k = 20; k <= 27; k++) send(20'(MID + k));
        tick();
        adc_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            adc_output = 20'(MID + 100 + (k % 50));
            tick();
        end
        adc_valid = 1'b0;
        tick();
        tick();
        check("sat_drops", 32'(drop_count), 32'd255);
        check("sat_ovf", 32'(overflow), 32'd1);
        check("sat_level", 32'(fifo_level), 32'd8);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("pulse_clr_ovf", 32'(overflow), 32'd0);
        check("pulse_clr_drops", 32'(drop_count), 32'd0);
        send(20'(MID + 200));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("coinc_ovf", 32'(overflow), 32'd1);
        check("coinc_drops", 32'(drop_count), 32'd1);
        check("coinc_head", 32'(pcm_data), 32'd20);
        for (int k = 20; k <= 27; k++) exp_q.push_back(16'(k));
        drain_check("coinc_pop");

        // Asynchronous reset with five stored and one in stage 1
        for (int k = 31; k <= 36; k++) begin
            adc_output = 20'(MID + k);
            adc_valid  = 1'b1;
            tick();
        end
        adc_valid = 1'b0;
        check("pre_rst_level", 32'(fifo_level), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_level", 32'(fifo_level), 32'd0);
        check("async_valid", 32'(pcm_valid), 32'd0);
        check("async_data", 32'(pcm_data), 32'd0);
        check("async_ovf", 32'(overflow), 32'd0);
        check("async_drops", 32'(drop_count), 32'd0);
        tick();
        rst_n     = 1'b1;
        pcm_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (pcm_valid) seen++;
            tick();
        end
        check("post_rst_seen", 32'(seen), 32'd0);

        // First sample after reset is processed normally
        send(20'(MID + 40));
        check("first_n1_level", 32'(fifo_level), 32'd0);
        tick();
        check("first_n2_valid", 32'(pcm_valid), 32'd1);
        check("first_n2_data", 32'(pcm_data), 32'd40);
        tick();
        check("first_done", 32'(fifo_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_pcm_fifo.md
ADC_PCM_FIFO -- requirements
Module: adc_pcm_fifo

Interface
REQ-001 SHALL have parameter IN_WDTH, default 20, the width of the sigma-delta ADC CIC output word.
REQ-002 SHALL have parameter FS_LOG2, default 16, where 2**FS_LOG2 is the ADC full-scale count (BOSR**CIC_STAGES = 256**2); PCM output width equals FS_LOG2.
REQ-003 SHALL have parameter DEPTH, default 8, the FIFO depth; a power of 2, at least 2.
REQ-004 SHALL run on one clock with an asynchronous, active-low reset; ports follow.
REQ-005 clk  input  1  rising-edge clock, same clock as the sigma-delta ADC.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 adc_output  input  IN_WDTH  unsigned offset-binary ADC sample.
REQ-008 adc_valid  input  1  single-cycle strobe qualifying adc_output.
REQ-009 pcm_data  output  FS_LOG2  signed two's-complement sample at FIFO head.
REQ-010 pcm_valid  output  1  FIFO non-empty.
REQ-011 pcm_ready  input  1  consumer accepts the head sample when high with pcm_valid.
REQ-012 fifo_level  output  clog2(DEPTH)+1  number of stored samples, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: a sample was dropped.
REQ-014 drop_count  output  8  count of dropped samples, saturating.
REQ-015 sat_pulse  output  1  one-cycle pulse: the sample leaving stage 2 was clipped.
REQ-016 ovf_clr  input  1  synchronous clear of overflow and drop_count.

Function
REQ-017 Stage 1: on adc_valid, SHALL register centered = adc_output - 2**(FS_LOG2-1), computed signed at IN_WDTH+1 bits, and set an internal stage-1 valid bit for one cycle.
REQ-018 Stage 2: SHALL clip centered to [-2**(FS_LOG2-1), 2**(FS_LOG2-1)-1], truncate to FS_LOG2 bits, and present it as a FIFO write request in the cycle following stage 1.
REQ-019 sat_pulse SHALL be high in exactly the cycle of the stage-2 write request when clipping changed the value; it is independent of whether the FIFO accepts the write.
REQ-020 Latency: adc_valid high in cycle N with an empty FIFO -> pcm_valid high and pcm_data valid in cycle N+2.
REQ-021 Read: pcm_valid && pcm_ready at a rising edge pops the head; order SHALL be strictly FIFO.
REQ-022 Write when fifo_level < DEPTH SHALL be accepted.
REQ-023 Write when fifo_level == DEPTH with a pop in the same cycle SHALL be accepted, and the level stays DEPTH.
REQ-024 Write when fifo_level == DEPTH without a pop SHALL be dropped, with stored data unchanged, overflow set, and drop_count incremented and saturating at 255.
REQ-025 Simultaneous write and pop at any level SHALL leave fifo_level unchanged.
REQ-026 pcm_ready while empty SHALL have no effect, and the level never underflows.
REQ-027 pcm_data SHALL be 0 whenever pcm_valid is low.
REQ-028 Pointers SHALL wrap modulo DEPTH, and full/empty SHALL be derived from a level or extra-bit pointer scheme, never ambiguous.
REQ-029 ovf_clr SHALL clear overflow and drop_count next edge; if a drop occurs in the same cycle, the drop wins (overflow=1, drop_count=1).
REQ-030 adc_valid pulses back-to-back every cycle SHALL be sustained without loss while the FIFO has room.

Reset
REQ-031 rst_n low SHALL immediately clear pointers, fifo_level=0, pcm_valid=0, pcm_data=0, overflow=0, drop_count=0, sat_pulse=0, and the stage valid bits, discarding in-flight samples.
REQ-032 After rst_n deasserts, the first adc_valid SHALL be processed normally with no spurious write.

Verification
REQ-033 adc_output=32768, pcm_ready=1 -> pcm_data=0x0000 in cycle N+2, sat_pulse=0.
REQ-034 adc_output=0 -> 0x8000 with sat_pulse=0; adc_output=65536 -> 0x7FFF with sat_pulse=1; adc_output=70000 -> 0x7FFF with sat_pulse=1.
REQ-035 pcm_ready=0, 9 samples 1..9 above midscale -> fifo_level=8, overflow=1, drop_count=1; then pcm_ready=1 pops samples 1..8 in order, and sample 9 is never seen.
REQ-036 Full FIFO with pcm_ready=1 and a concurrent write -> level stays 8, no drop, and the new sample appears last.
REQ-037 300 drops -> drop_count=255; ovf_clr pulse -> 0/0; ovf_clr coincident with a drop -> overflow=1, drop_count=1.
REQ-038 rst_n asserted with 5 stored samples and one in stage 1 -> level=0, pcm_valid=0 immediately, and no sample emerges after release.
